// File: rtl/rsp_xarb.sv
// Response-path allocator: per-target round-robin arbitration with packet lock.
// Drives the crossbar one-hot requests and carries valid/ready around the datapath.
module rsp_xarb #(
  parameter int NI = 5,
  parameter int NT = 3,
  parameter logic [NI*NT-1:0] CONN = 15'h4E4C,
  localparam int TW = (NT > 1) ? $clog2(NT) : 1,
  localparam int IW = (NI > 1) ? $clog2(NI) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NI-1:0]    src_valid,
  input  logic [NI*TW-1:0] src_dst,
  input  logic [NI-1:0]    src_last,
  output logic [NI-1:0]    src_ready,
  input  logic [NT-1:0]    tgt_ready,
  output logic [NT-1:0]    tgt_valid,
  output logic [NI*NT-1:0] I_req,
  output logic [NI-1:0]    err_unroutable
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;

  state_e        state_q [NT];
  state_e        state_d [NT];
  logic [IW-1:0] owner_q [NT];
  logic [IW-1:0] owner_d [NT];
  logic [IW-1:0] rr_q    [NT];
  logic [IW-1:0] rr_d    [NT];
  logic [NI-1:0] err_q, err_d;

  logic [TW-1:0] dst [NI];
  logic [NI-1:0] owns_any, routable, elig;
  logic [NT-1:0] any_elig, xfer;
  logic [IW-1:0] pick [NT];
  logic [IW:0]   cand_sum;

  genvar gi;
  for (gi = 0; gi < NI; gi++) begin : g_dst
    assign dst[gi] = src_dst[gi*TW +: TW];
  end

  // Arbitration only ever looks at registered ownership, so src_dst never reaches I_req.
  always_comb begin
    owns_any = '0;
    for (int t = 0; t < NT; t++) begin
      if (state_q[t] == LOCKED) owns_any[owner_q[t]] = 1'b1;
    end
  end

  always_comb begin
    routable = '0;
    for (int k = 0; k < NI; k++) begin
      for (int t = 0; t < NT; t++) begin
        if (dst[k] == TW'(t) && CONN[k*NT+t]) routable[k] = 1'b1;
      end
    end
  end

  always_comb begin
    elig     = '0;
    cand_sum = '0;
    any_elig = '0;
    for (int t = 0; t < NT; t++) begin
      pick[t] = '0;
      for (int k = 0; k < NI; k++) begin
        elig[k] = src_valid[k] && (dst[k] == TW'(t)) && CONN[k*NT+t] && !owns_any[k];
      end
      for (int i = 0; i < NI; i++) begin
        cand_sum = {1'b0, rr_q[t]} + (IW+1)'(i);
        if (cand_sum >= (IW+1)'(NI)) cand_sum = cand_sum - (IW+1)'(NI);
        if (!any_elig[t] && elig[cand_sum[IW-1:0]]) begin
          any_elig[t] = 1'b1;
          pick[t]     = cand_sum[IW-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < NT; t++) begin
        state_q[t] <= IDLE;
        owner_q[t] <= '0;
        rr_q[t]    <= '0;
      end
      err_q <= '0;
    end else begin
      for (int t = 0; t < NT; t++) begin
        state_q[t] <= state_d[t];
        owner_q[t] <= owner_d[t];
        rr_q[t]    <= rr_d[t];
      end
      err_q <= err_d;
    end
  end

  always_comb begin
    for (int t = 0; t < NT; t++) begin
      state_d[t] = state_q[t];
      owner_d[t] = owner_q[t];
      rr_d[t]    = rr_q[t];
      case (state_q[t])
        IDLE: begin
          if (any_elig[t]) begin
            state_d[t] = LOCKED;
            owner_d[t] = pick[t];
          end
        end
        LOCKED: begin
          if (xfer[t] && src_last[owner_q[t]]) begin
            state_d[t] = IDLE;
            rr_d[t]    = (owner_q[t] == IW'(NI-1)) ? '0 : owner_q[t] + 1'b1;
          end
        end
        default: state_d[t] = IDLE;
      endcase
    end
    err_d = err_q | (src_valid & ~routable);
  end

  always_comb begin
    I_req     = '0;
    tgt_valid = '0;
    src_ready = '0;
    xfer      = '0;
    for (int t = 0; t < NT; t++) begin
      if (state_q[t] == LOCKED) begin
        I_req[int'(owner_q[t])*NT + t] = 1'b1;
        tgt_valid[t]                   = src_valid[owner_q[t]];
        src_ready[owner_q[t]]          = tgt_ready[t];
        xfer[t]                        = src_valid[owner_q[t]] & tgt_ready[t];
      end
    end
  end

  assign err_unroutable = err_q;

`ifndef SYNTHESIS
  for (gi = 0; gi < NI; gi++) begin : g_src_chk
    a_row_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(I_req[gi*NT +: NT]));
    a_dst_stable : assert property (@(posedge clk) disable iff (!rst_n)
      (src_valid[gi] && !src_ready[gi]) |=> (!src_valid[gi] || $stable(src_dst[gi*TW +: TW])));
  end
  for (gi = 0; gi < NT; gi++) begin : g_tgt_chk
    logic [NI-1:0] col;
    always_comb begin
      col = '0;
      for (int k = 0; k < NI; k++) col[k] = I_req[k*NT + gi];
    end
    a_col_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(col));
  end
`endif

endmodule

// File: tb/tb_rsp_xarb.sv
// Self-checking bench for rsp_xarb: directed scenarios plus randomized traffic,
// all compared against a transaction-level model of the allocator.
module tb_rsp_xarb;
  localparam int NI = 5;
  localparam int NT = 3;
  localparam int TW = 2;
  localparam logic [NI*NT-1:0] CONN = 15'h4E4C;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NI-1:0]    src_valid;
  logic [NI*TW-1:0] src_dst;
  logic [NI-1:0]    src_last;
  logic [NI-1:0]    src_ready;
  logic [NT-1:0]    tgt_ready;
  logic [NT-1:0]    tgt_valid;
  logic [NI*NT-1:0] I_req;
  logic [NI-1:0]    err_unroutable;

  int n_vec = 0;
  int miscompares = 0;

  rsp_xarb dut (
    .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_dst(src_dst),
    .src_last(src_last), .src_ready(src_ready), .tgt_ready(tgt_ready),
    .tgt_valid(tgt_valid), .I_req(I_req), .err_unroutable(err_unroutable)
  );

  always #5 clk = ~clk;

  // Reference model: who holds each target, where its round-robin resumes, sticky errors.
  bit               m_lock  [NT];
  int               m_owner [NT];
  int               m_rr    [NT];
  logic [NI-1:0]    m_err;
  logic [NI-1:0]    m_fired;
  logic [NI*NT-1:0] exp_ireq;
  logic [NT-1:0]    exp_tv;
  logic [NI-1:0]    exp_sr;

  function automatic int dst_of(int k);
    return int'(src_dst[k*TW +: TW]);
  endfunction

  function automatic bit conn(int k, int t);
    logic [NI*NT-1:0] c = CONN;
    return c[k*NT+t];
  endfunction

  function automatic void model_reset();
    for (int t = 0; t < NT; t++) begin
      m_lock[t] = 0; m_owner[t] = 0; m_rr[t] = 0;
    end
    m_err = '0;
    m_fired = '0;
  endfunction

  function automatic void model_eval();
    exp_ireq = '0; exp_tv = '0; exp_sr = '0;
    for (int t = 0; t < NT; t++) begin
      if (m_lock[t]) begin
        exp_ireq[m_owner[t]*NT + t] = 1'b1;
        exp_tv[t] = src_valid[m_owner[t]];
        exp_sr[m_owner[t]] = tgt_ready[t];
      end
    end
  endfunction

  function automatic void model_commit();
    bit busy [NI];
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_fired = '0;
    for (int k = 0; k < NI; k++) busy[k] = 0;
    for (int t = 0; t < NT; t++) if (m_lock[t]) busy[m_owner[t]] = 1;
    for (int t = 0; t < NT; t++) begin
      if (m_lock[t]) begin
        int o = m_owner[t];
        if (src_valid[o] && tgt_ready[t]) begin
          m_fired[o] = 1'b1;
          if (src_last[o]) begin
            m_lock[t] = 0;
            m_rr[t] = (o + 1) % NI;
          end
        end
      end else begin
        for (int i = 0; i < NI; i++) begin
          int k = (m_rr[t] + i) % NI;
          if (src_valid[k] && dst_of(k) == t && conn(k, t) && !busy[k]) begin
            m_lock[t] = 1; m_owner[t] = k;
            break;
          end
        end
      end
    end
    for (int k = 0; k < NI; k++)
      if (src_valid[k] && (dst_of(k) >= NT || !conn(k, dst_of(k)))) m_err[k] = 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    src_valid = '0; src_dst = '0; src_last = '0; tgt_ready = '0;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    src_valid = '1; src_dst = '0; src_last = '1; tgt_ready = '1;
    model_reset();
    for (int c = 0; c < 2; c++) begin
      #1;
      n_vec++;
      if ({I_req, tgt_valid, src_ready, err_unroutable} !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs cyc=%0d got ireq=%h tv=%b sr=%b err=%b required all zero",
                 c, I_req, tgt_valid, src_ready, err_unroutable);
      end
      tick();
    end
    src_valid = '0; src_last = '0; tgt_ready = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_single_packet();
    logic [NI*NT-1:0] want;
    do_reset();
    tgt_ready = '1;
    for (int c = 0; c < 5; c++) begin
      src_valid = (c < 4) ? 5'b01000 : 5'b00000;
      src_dst[3*TW +: TW] = 2'd1;
      src_last[3] = (c == 3);
      #1; model_eval();
      n_vec++;
      if ({I_req, tgt_valid, src_ready, err_unroutable} !== {exp_ireq, exp_tv, exp_sr, m_err}) begin
        miscompares++;
        $display("FAIL single_model cyc=%0d got ireq=%h tv=%b sr=%b exp ireq=%h tv=%b sr=%b",
                 c, I_req, tgt_valid, src_ready, exp_ireq, exp_tv, exp_sr);
      end
      want = (c >= 1 && c <= 3) ? 15'h0400 : 15'h0000;
      n_vec++;
      if (I_req !== want || src_ready[3] !== (c >= 1 && c <= 3)) begin
        miscompares++;
        $display("FAIL single_xfer cyc=%0d got ireq=%h sr3=%b required ireq=%h sr3=%b",
                 c, I_req, src_ready[3], want, (c >= 1 && c <= 3));
      end
      tick();
    end
  endtask

  task automatic test_contention();
    int grants[$];
    int exp_order[4] = '{1, 2, 3, 1};
    logic [NI-1:0] col;
    do_reset();
    tgt_ready = '1;
    src_valid = 5'b01110;
    src_dst = '0;
    src_last = '1;
    for (int c = 0; c < 8; c++) begin
      #1; model_eval();
      n_vec++;
      if ({I_req, tgt_valid, src_ready, err_unroutable} !== {exp_ireq, exp_tv, exp_sr, m_err}) begin
        miscompares++;
        $display("FAIL contention_model cyc=%0d got ireq=%h sr=%b exp ireq=%h sr=%b",
                 c, I_req, src_ready, exp_ireq, exp_sr);
      end
      for (int k = 0; k < NI; k++) col[k] = I_req[k*NT];
      n_vec++;
      if (!$onehot0(col)) begin
        miscompares++;
        $display("FAIL contention_col0 cyc=%0d got col=%b required onehot0", c, col);
      end
      for (int k = 0; k < NI; k++) if (col[k]) grants.push_back(k);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (i >= grants.size() || grants[i] != exp_order[i]) begin
        miscompares++;
        $display("FAIL contention_order grant%0d got I%0d required I%0d",
                 i, (i < grants.size()) ? grants[i] : -1, exp_order[i]);
      end
    end
  endtask

  task automatic test_parallel();
    do_reset();
    tgt_ready = '0;
    src_valid = 5'b01011;
    src_dst = '0;
    src_dst[0*TW +: TW] = 2'd2;
    src_dst[1*TW +: TW] = 2'd0;
    src_dst[3*TW +: TW] = 2'd1;
    src_last = '1;
    for (int c = 0; c < 2; c++) begin
      #1; model_eval();
      n_vec++;
      if (I_req !== exp_ireq || tgt_valid !== exp_tv) begin
        miscompares++;
        $display("FAIL parallel_model cyc=%0d got ireq=%h tv=%b exp ireq=%h tv=%b",
                 c, I_req, tgt_valid, exp_ireq, exp_tv);
      end
      n_vec++;
      if (I_req !== ((c == 1) ? 15'h040C : 15'h0000)) begin
        miscompares++;
        $display("FAIL parallel_grant cyc=%0d got ireq=%h required %h",
                 c, I_req, (c == 1) ? 15'h040C : 15'h0000);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    src_valid = 5'b10000;
    src_dst[4*TW +: TW] = 2'd2;
    src_last = '1;
    for (int c = 0; c < 7; c++) begin
      tgt_ready = (c >= 5) ? 3'b111 : 3'b011;
      if (c == 6) src_valid = '0;
      #1; model_eval();
      n_vec++;
      if ({I_req, tgt_valid, src_ready, err_unroutable} !== {exp_ireq, exp_tv, exp_sr, m_err}) begin
        miscompares++;
        $display("FAIL backpressure_model cyc=%0d got ireq=%h tv=%b sr=%b exp ireq=%h tv=%b sr=%b",
                 c, I_req, tgt_valid, src_ready, exp_ireq, exp_tv, exp_sr);
      end
      if (c >= 1 && c <= 5) begin
        n_vec++;
        if (I_req[14] !== 1'b1 || tgt_valid[2] !== 1'b1 || src_ready[4] !== (c == 5)) begin
          miscompares++;
          $display("FAIL backpressure_hold cyc=%0d got req=%b tv2=%b sr4=%b required 1 1 %b",
                   c, I_req[14], tgt_valid[2], src_ready[4], (c == 5));
        end
      end
      if (c == 6) begin
        n_vec++;
        if (I_req !== '0) begin
          miscompares++;
          $display("FAIL backpressure_release got ireq=%h required 0", I_req);
        end
      end
      tick();
    end
  endtask

  task automatic test_unroutable();
    do_reset();
    tgt_ready = '1;
    src_valid = 5'b00011;
    src_dst = '0;
    src_last = '1;
    for (int c = 0; c < 8; c++) begin
      if (c == 7) src_valid = '0;
      #1; model_eval();
      n_vec++;
      if ({I_req, tgt_valid, src_ready, err_unroutable} !== {exp_ireq, exp_tv, exp_sr, m_err}) begin
        miscompares++;
        $display("FAIL unroutable_model cyc=%0d got ireq=%h sr=%b err=%b exp ireq=%h sr=%b err=%b",
                 c, I_req, src_ready, err_unroutable, exp_ireq, exp_sr, m_err);
      end
      n_vec++;
      if (err_unroutable !== ((c == 0) ? 5'b00000 : 5'b00001) || I_req[2:0] !== 3'b000 ||
          src_ready[0] !== 1'b0) begin
        miscompares++;
        $display("FAIL unroutable_flag cyc=%0d got err=%b i0req=%b sr0=%b required err=%b 000 0",
                 c, err_unroutable, I_req[2:0], src_ready[0], (c == 0) ? 5'b00000 : 5'b00001);
      end
      if (c == 1) begin
        n_vec++;
        if (I_req[3] !== 1'b1) begin
          miscompares++;
          $display("FAIL unroutable_other got I1_req_T0=%b required 1", I_req[3]);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    tgt_ready = '1;
    src_valid = 5'b00010; src_dst = '0; src_last = '1;
    tick();
    tick();
    src_valid = 5'b01000; src_dst[3*TW +: TW] = 2'd1; src_last = '0;
    tick();
    #1;
    n_vec++;
    if (I_req !== 15'h0400) begin
      miscompares++;
      $display("FAIL midreset_locked got ireq=%h required 0400", I_req);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (I_req !== '0 || tgt_valid !== '0 || src_ready !== '0) begin
      miscompares++;
      $display("FAIL midreset_clear got ireq=%h tv=%b sr=%b required all zero",
               I_req, tgt_valid, src_ready);
    end
    model_reset();
    tick();
    rst_n = 1'b1;
    src_valid = 5'b00110; src_dst = '0; src_last = '1;
    #1;
    n_vec++;
    if (I_req !== '0) begin
      miscompares++;
      $display("FAIL midreset_idle got ireq=%h required 0", I_req);
    end
    tick();
    #1;
    n_vec++;
    if (I_req !== 15'h0008) begin
      miscompares++;
      $display("FAIL midreset_rr0 got ireq=%h required 0008 (I1 first)", I_req);
    end
    tick();
  endtask

  task automatic test_random(int ncyc);
    logic [NI-1:0] col;
    bit col_ok;
    int d;
    do_reset();
    for (int c = 0; c < ncyc; c++) begin
      for (int k = 0; k < NI; k++) begin
        bit owned = 0;
        for (int t = 0; t < NT; t++) if (m_lock[t] && m_owner[t] == k) owned = 1;
        if (m_fired[k] && src_last[k]) src_valid[k] = 1'b0;
        else if (owned) src_valid[k] = ($urandom_range(0, 3) != 0);
        else if (src_valid[k]) begin
          if ($urandom_range(0, 7) == 0) src_valid[k] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          if ($urandom_range(0, 9) == 0) d = int'($urandom_range(0, 3));
          else if (k == 3) d = int'($urandom_range(0, 2));
          else if (k == 1 || k == 2) d = 0;
          else d = 2;
          src_valid[k] = 1'b1;
          src_dst[k*TW +: TW] = 2'(d);
        end
        src_last[k] = ($urandom_range(0, 2) == 0);
      end
      tgt_ready = 3'($urandom_range(0, 7));
      #1; model_eval();
      n_vec++;
      if ({I_req, tgt_valid, src_ready, err_unroutable} !== {exp_ireq, exp_tv, exp_sr, m_err}) begin
        miscompares++;
        $display("FAIL random_model cyc=%0d got ireq=%h tv=%b sr=%b err=%b exp ireq=%h tv=%b sr=%b err=%b",
                 c, I_req, tgt_valid, src_ready, err_unroutable, exp_ireq, exp_tv, exp_sr, m_err);
      end
      col_ok = 1;
      for (int t = 0; t < NT; t++) begin
        for (int k = 0; k < NI; k++) col[k] = I_req[k*NT + t];
        if (!$onehot0(col)) col_ok = 0;
      end
      n_vec++;
      if (!col_ok) begin
        miscompares++;
        $display("FAIL random_columns cyc=%0d got ireq=%h required onehot0 columns", c, I_req);
      end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    src_valid = '0; src_dst = '0; src_last = '0; tgt_ready = '0;
    model_reset();
    test_reset();
    test_single_packet();
    test_contention();
    test_parallel();
    test_backpressure();
    test_unroutable();
    test_reset_mid_packet();
    test_random(1500);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
    $finish;
  end

endmodule
